xor_parity_stream: RTL and testbench
====================================

Name: xor_parity_stream

Overview:
- Parametrised, streaming successor to the single-bit XOR gate: XOR-reduces a multi-lane data stream per lane across all beats of a frame.
- Produces per-lane even/odd parity, compares it against expected parity supplied on the last beat, and reports a mismatch flag plus the frame beat count.
- Sits between a valid/ready data source and a status/consumer port as a frame integrity generator/checker.

Parameters:
- DATA_W, 32, input data width in bits; must be a multiple of LANE_W.
- LANE_W, 8, bits per parity lane; LANES = DATA_W/LANE_W.
- CNT_W, 8, width of the saturating beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_W  beat data.
- in_last  in  1  final beat of frame.
- in_exp_par  in  LANES  expected per-lane parity; sampled only on the last beat.
- mode_odd  in  1  0 = even parity, 1 = odd parity; sampled on the first beat of a frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts result.
- out_parity  out  LANES  bit i = parity of lane i (bits i*LANE_W+LANE_W-1 : i*LANE_W) over the whole frame.
- out_err  out  1  1 when out_parity != captured in_exp_par.
- out_beats  out  CNT_W  number of beats in the frame, saturating.
- out_sat  out  1  beat counter saturated in this frame.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0 (in_ready = 0 while rst_n is low, 1 from the first cycle after release). FSM = IDLE; accumulators, counter, mode and expected-parity registers = 0.
- Handshake: a beat transfers when in_valid && in_ready. A result transfers when out_valid && out_ready.
- FSM states IDLE, ACCUM, HOLD:
  - IDLE: in_ready = 1. An accepted beat loads acc[i] = ^lane_i(in_data), cnt = 1, and latches mode_odd. Goes to HOLD if in_last, else to ACCUM.
  - ACCUM: in_ready = 1. An accepted beat does acc[i] ^= ^lane_i(in_data) and cnt += 1. in_last goes to HOLD. With no valid beat the state holds.
  - HOLD: in_ready = 0. out_valid = 1. out_parity = acc ^ {LANES{mode_lat}}. out_err = |(out_parity ^ exp_lat). Goes to IDLE on out_ready.
- Latency: out_valid rises the cycle after the last beat is accepted. Outputs are registered and remain stable while out_valid && !out_ready.
- Throughput: one frame per (beats + 1) cycles minimum. No beat is accepted in HOLD.
- in_exp_par is latched only on the accepting last beat. mode_odd changes mid-frame are ignored.
- Counter: when cnt == 2^CNT_W-1 it stays there and out_sat = 1 for that frame. Saturation does not affect parity accumulation.
- Result values while out_valid = 0: out_parity, out_err, out_beats and out_sat are held at 0.
- Reset mid-frame (any state): the partial frame is discarded and no result is emitted. The next frame starts clean.
- Single-beat frame (first beat has in_last): IDLE goes directly to HOLD.

Decomposition:
- Shared package: FSM state enum (IDLE/ACCUM/HOLD), the LANES derivation function, and the parity-mode encoding constants.
- One sub-module: lane_xor_reduce, a combinational DATA_W to LANES per-lane XOR reduction, parametrised by DATA_W and LANE_W.

Test Plan (DATA_W=32, LANE_W=8, CNT_W=8 unless stated):
- One beat 0x00000000, last, mode_odd=0, exp=4'b0000 -> next cycle out_valid=1, parity 4'b0000, err 0, beats 1.
- Beats 0x01000003, 0x01000000, 0x00000001 (last), mode_odd=1, exp=4'b1110 -> parity 4'b1110, err 0, beats 3, out_sat 0.
- One beat 0x000000FF, last, mode_odd=0, exp=4'b0001 -> parity 4'b0000, err 1.
- Complete a frame, hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout. Assert out_ready -> out_valid=0 and in_ready=1 next cycle.
- Send 2 beats without last, pulse rst_n low, then one beat 0x00000001 last, mode 0 -> no earlier result; result parity 4'b0001, beats 1.
- CNT_W=4: 20-beat frame of 0x00000000 -> out_beats=15, out_sat=1, parity 4'b0000.

Source files
------------

// File: rtl/xor_parity_stream_pkg.sv
//==============================================================================
// Module : xor_parity_stream_pkg
// Brief  : Shared types and helpers for the streaming per-lane parity block.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package xor_parity_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic c_MODE_EVEN = 1'b0;
    localparam logic c_MODE_ODD  = 1'b1;

    function automatic int calc_lanes(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xor_parity_stream_lane_xor_reduce.sv
//==============================================================================
// Module : lane_xor_reduce
// Brief  : Combinational per-lane XOR reduction of a DATA_W word.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lane_xor_reduce
    import xor_parity_stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    parameter int LANES  = calc_lanes(DATA_W, LANE_W)
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [LANES-1:0]  o_par
);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign o_par[gi] = ^i_data[gi*LANE_W +: LANE_W];
    end

endmodule

`default_nettype wire

// File: rtl/xor_parity_stream.sv
//==============================================================================
// Module : xor_parity_stream
// Brief  : Frame-level per-lane parity generator/checker on a valid/ready stream.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module xor_parity_stream
    import xor_parity_stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    parameter int CNT_W  = 8,
    parameter int LANES  = calc_lanes(DATA_W, LANE_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [LANES-1:0]  in_exp_par,
    input  logic              mode_odd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANES-1:0]  out_parity,
    output logic              out_err,
    output logic [CNT_W-1:0]  out_beats,
    output logic              out_sat
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [LANES-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mode;
    logic [LANES-1:0]   r_exp;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [LANES-1:0]   r_out_parity;
    logic               r_out_err;
    logic [CNT_W-1:0]   r_out_beats;
    logic               r_out_sat;

    logic [LANES-1:0]   w_lane_par;
    logic               w_beat;
    logic               w_first;
    logic [LANES-1:0]   w_acc_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_mode_eff;
    logic [LANES-1:0]   w_par_final;
    logic               w_err_final;

    lane_xor_reduce #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W),
        .LANES  (LANES)
    ) u_reduce (
        .i_data (in_data),
        .o_par  (w_lane_par)
    );

    assign w_beat     = in_valid && r_in_ready;
    assign w_first    = (r_state == ST_IDLE);
    assign w_acc_next = w_first ? w_lane_par : (r_acc ^ w_lane_par);
    assign w_cnt_next = w_first ? c_CNT_ONE
                      : ((r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE);
    // Mode is taken live on the first beat, from the latch thereafter.
    assign w_mode_eff  = w_first ? mode_odd : r_mode;
    assign w_par_final = w_acc_next ^ {LANES{w_mode_eff}};
    assign w_err_final = |(w_par_final ^ in_exp_par);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_mode       <= c_MODE_EVEN;
            r_exp        <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_parity <= '0;
            r_out_err    <= 1'b0;
            r_out_beats  <= '0;
            r_out_sat    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    r_in_ready <= 1'b1;
                    if (w_beat) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                        if (w_first) begin
                            r_mode <= mode_odd;
                        end
                        if (in_last) begin
                            r_exp        <= in_exp_par;
                            r_state      <= ST_HOLD;
                            r_in_ready   <= 1'b0;
                            r_out_valid  <= 1'b1;
                            r_out_parity <= w_par_final;
                            r_out_err    <= w_err_final;
                            r_out_beats  <= w_cnt_next;
                            r_out_sat    <= (w_cnt_next == c_CNT_MAX);
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    r_in_ready <= 1'b0;
                    if (out_ready) begin
                        r_state      <= ST_IDLE;
                        r_in_ready   <= 1'b1;
                        r_acc        <= '0;
                        r_cnt        <= '0;
                        r_out_valid  <= 1'b0;
                        r_out_parity <= '0;
                        r_out_err    <= 1'b0;
                        r_out_beats  <= '0;
                        r_out_sat    <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_parity = r_out_parity;
    assign out_err    = r_out_err;
    assign out_beats  = r_out_beats;
    assign out_sat    = r_out_sat;

endmodule

`default_nettype wire

// File: tb/tb_xor_parity_stream.sv
//==============================================================================
// Module : tb_xor_parity_stream
// Brief  : Directed self-checking bench for xor_parity_stream.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_xor_parity_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic [3:0]  in_exp_par;
    logic        mode_odd;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out_parity;
    logic        out_err;
    logic [7:0]  out_beats;
    logic        out_sat;

    logic        in_ready4;
    logic        out_valid4;
    logic [3:0]  out_parity4;
    logic        out_err4;
    logic [3:0]  out_beats4;
    logic        out_sat4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xor_parity_stream #(.DATA_W(32), .LANE_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_exp_par(in_exp_par),
        .mode_odd(mode_odd), .out_valid(out_valid), .out_ready(out_ready),
        .out_parity(out_parity), .out_err(out_err), .out_beats(out_beats),
        .out_sat(out_sat)
    );

    // Narrow-counter instance sharing the same stream for the saturation case.
    xor_parity_stream #(.DATA_W(32), .LANE_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_last(in_last), .in_exp_par(in_exp_par),
        .mode_odd(mode_odd), .out_valid(out_valid4), .out_ready(out_ready),
        .out_parity(out_parity4), .out_err(out_err4), .out_beats(out_beats4),
        .out_sat(out_sat4)
    );

    task automatic send_beat(input logic [31:0] d, input logic last,
                             input logic [3:0] exp, input logic mode);
        int t;
        in_valid   = 1'b1;
        in_data    = d;
        in_last    = last;
        in_exp_par = exp;
        mode_odd   = mode;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_exp_par = '0; mode_odd = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, out_parity, out_err, out_beats, out_sat} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b v=%b p=%b e=%b b=%0d s=%b, required all 0",
                     in_ready, out_valid, out_parity, out_err, out_beats, out_sat);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_single_zero();
        send_beat(32'h0000_0000, 1'b1, 4'b0000, 1'b0);
        n_checks++;
        if ({out_valid, out_parity, out_err, out_beats} !== {1'b1, 4'b0000, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL single_zero: got v=%b p=%b e=%b b=%0d, required v=1 p=0000 e=0 b=1",
                     out_valid, out_parity, out_err, out_beats);
        end
        consume();
    endtask

    task automatic test_three_beat_odd();
        send_beat(32'h0100_0003, 1'b0, 4'b0000, 1'b1);
        send_beat(32'h0100_0000, 1'b0, 4'b0000, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL three_beat_early_valid: got %b, required 0", out_valid);
        end
        send_beat(32'h0000_0001, 1'b1, 4'b1110, 1'b0);
        n_checks++;
        if ({out_valid, out_parity, out_err, out_beats, out_sat} !==
            {1'b1, 4'b1110, 1'b0, 8'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL three_beat_odd: got v=%b p=%b e=%b b=%0d s=%b, required v=1 p=1110 e=0 b=3 s=0",
                     out_valid, out_parity, out_err, out_beats, out_sat);
        end
        consume();
    endtask

    task automatic test_error();
        send_beat(32'h0000_00FF, 1'b1, 4'b0001, 1'b0);
        n_checks++;
        if ({out_valid, out_parity, out_err} !== {1'b1, 4'b0000, 1'b1}) begin
            n_fail++;
            $display("FAIL parity_error: got v=%b p=%b e=%b, required v=1 p=0000 e=1",
                     out_valid, out_parity, out_err);
        end
        consume();
    endtask

    task automatic test_backpressure();
        send_beat(32'h0001_0000, 1'b1, 4'b0100, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFE;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({out_valid, out_parity, out_err, out_beats, in_ready} !==
                {1'b1, 4'b0100, 1'b0, 8'd1, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got v=%b p=%b e=%b b=%0d rdy=%b, required v=1 p=0100 e=0 b=1 rdy=0",
                         i, out_valid, out_parity, out_err, out_beats, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        consume();
        n_checks++;
        if ({out_valid, in_ready, out_parity, out_beats} !== {1'b0, 1'b1, 4'b0000, 8'd0}) begin
            n_fail++;
            $display("FAIL hold_release: got v=%b rdy=%b p=%b b=%0d, required v=0 rdy=1 p=0000 b=0",
                     out_valid, in_ready, out_parity, out_beats);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_beat(32'h0000_00F1, 1'b0, 4'b1111, 1'b1);
        send_beat(32'h0300_0000, 1'b0, 4'b1111, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_outputs: got v=%b rdy=%b, required 00", out_valid, in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_result: got v=%b, required 0", out_valid);
        end
        send_beat(32'h0000_0001, 1'b1, 4'b0001, 1'b0);
        n_checks++;
        if ({out_valid, out_parity, out_err, out_beats} !== {1'b1, 4'b0001, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL midreset_clean_frame: got v=%b p=%b e=%b b=%0d, required v=1 p=0001 e=0 b=1",
                     out_valid, out_parity, out_err, out_beats);
        end
        consume();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            send_beat(32'h0000_0000, (i == 19), 4'b0000, 1'b0);
        end
        n_checks++;
        if ({out_valid4, out_beats4, out_sat4, out_parity4, out_err4} !==
            {1'b1, 4'd15, 1'b1, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_cnt4: got v=%b b=%0d s=%b p=%b e=%b, required v=1 b=15 s=1 p=0000 e=0",
                     out_valid4, out_beats4, out_sat4, out_parity4, out_err4);
        end
        n_checks++;
        if ({out_valid, out_beats, out_sat} !== {1'b1, 8'd20, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_cnt8: got v=%b b=%0d s=%b, required v=1 b=20 s=0",
                     out_valid, out_beats, out_sat);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        send_beat(32'h8000_0000, 1'b1, 4'b0000, 1'b1);
        n_checks++;
        if ({out_parity, out_err} !== {4'b0111, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_first: got p=%b e=%b, required p=0111 e=1", out_parity, out_err);
        end
        consume();
        send_beat(32'h0101_0101, 1'b0, 4'b0000, 1'b0);
        send_beat(32'h0001_0001, 1'b1, 4'b1010, 1'b1);
        n_checks++;
        if ({out_parity, out_err, out_beats} !== {4'b1010, 1'b0, 8'd2}) begin
            n_fail++;
            $display("FAIL b2b_second: got p=%b e=%b b=%0d, required p=1010 e=0 b=2",
                     out_parity, out_err, out_beats);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_single_zero();
        test_three_beat_odd();
        test_error();
        test_backpressure();
        test_reset_mid_frame();
        test_saturation();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
